// File: rtl/i2c_slave.sv
// I2C target answering one 7-bit address. SCL/SDA are oversampled on clk;
// START/STOP are detected while SCL is high, data is sampled on SCL rises and
// the open-drain SDA drive is updated on SCL falls. Bytes travel LSB first;
// address byte bit 7 is the direction (1 = write, 0 = read).
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_MACK
    } state_t;

    // Input synchronizers plus one history flop per line
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    state_t     state_q,     state_d;
    logic [2:0] cnt_q,       cnt_d;
    logic [7:0] shift_q,     shift_d;
    logic       oe_q,        oe_d;
    logic       busy_q,      busy_d;
    logic       addressed_q, addressed_d;
    logic       dir_q,       dir_d;
    logic       mack_q,      mack_d;
    logic [7:0] rx_data_q,   rx_data_d;
    logic       wr_stb_q,    wr_stb_d;
    logic       rx_valid_q;
    logic       addr_hit_q,  addr_hit_d;
    logic       tx_req_q,    tx_req_d;
    logic       done_q,      done_d;

    logic [7:0] byte_in;

    // Open-drain: only ever pull low or release
    assign sda = oe_q ? 1'b0 : 1'bz;

    // Synchronize the bus lines into the clk domain; idle bus reads high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    // Incoming byte after shifting in the current SDA sample (LSB first)
    assign byte_in = {sda_s, shift_q[7:1]};

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
            dir_q       <= 1'b0;
            mack_q      <= 1'b0;
            rx_data_q   <= '0;
            wr_stb_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            addr_hit_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            addressed_q <= addressed_d;
            dir_q       <= dir_d;
            mack_q      <= mack_d;
            rx_data_q   <= rx_data_d;
            wr_stb_q    <= wr_stb_d;
            rx_valid_q  <= wr_stb_q;
            addr_hit_q  <= addr_hit_d;
            tx_req_q    <= tx_req_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: bus conditions first, then per-state bit handling
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        addressed_d = addressed_q;
        dir_d       = dir_q;
        mack_d      = mack_q;
        rx_data_d   = rx_data_q;
        wr_stb_d    = 1'b0;
        addr_hit_d  = 1'b0;
        tx_req_d    = 1'b0;
        done_d      = 1'b0;

        if (stop_det) begin
            // addressed_q outlives busy across a read NACK so the closing
            // STOP of an addressed read still reports done
            state_d     = S_IDLE;
            oe_d        = 1'b0;
            busy_d      = 1'b0;
            mack_d      = 1'b0;
            done_d      = addressed_q;
            addressed_d = 1'b0;
        end else if (start_det) begin
            state_d     = S_ADDR;
            cnt_d       = '0;
            oe_d        = 1'b0;
            busy_d      = 1'b0;
            mack_d      = 1'b0;
            addressed_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    oe_d = 1'b0;
                end

                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (byte_in[6:0] == SLAVE_ADDR) begin
                                state_d     = S_ADDR_ACK;
                                addr_hit_d  = 1'b1;
                                busy_d      = 1'b1;
                                addressed_d = 1'b1;
                                dir_d       = byte_in[7];
                                tx_req_d    = ~byte_in[7];
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end

                // oe_q doubles as the ACK phase flag: the first fall pulls
                // SDA low, the second ends the ACK slot
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            cnt_d = '0;
                            if (dir_q) begin
                                oe_d    = 1'b0;
                                state_d = S_WR_DATA;
                            end else begin
                                shift_d = tx_data;
                                oe_d    = ~tx_data[0];
                                state_d = S_RD_DATA;
                            end
                        end
                    end
                end

                S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_d = byte_in;
                            wr_stb_d  = 1'b1;
                            state_d   = S_WR_ACK;
                        end
                    end
                end

                S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = S_WR_DATA;
                        end
                    end
                end

                // Rotate so the bit on the bus is always shift_q[0]
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            oe_d    = 1'b0;
                            mack_d  = 1'b0;
                            state_d = S_RD_MACK;
                        end else begin
                            shift_d = {shift_q[0], shift_q[7:1]};
                            oe_d    = ~shift_q[1];
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end
                end

                S_RD_MACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            mack_d   = 1'b1;
                            tx_req_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && mack_q) begin
                        mack_d  = 1'b0;
                        shift_d = tx_data;
                        oe_d    = ~tx_data[0];
                        cnt_d   = '0;
                        state_d = S_RD_DATA;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    assign tx_req   = tx_req_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign addr_hit = addr_hit_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master drives the bus, pulse
// counters watch the status outputs, and directed transactions are checked
// against hand-computed values.
module tb_i2c_slave;

    logic       clk;
    logic       rst;
    logic       scl_r;
    logic       m_sda_oe;
    wire        sda;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_hit;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;

    int n_hit;
    int n_rxv;
    int n_txreq;
    int n_done;
    int n_slow;
    logic [7:0] rx_log[$];

    assign sda = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(
        .SLAVE_ADDR (7'h48),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl_r),
        .sda     (sda),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .addr_hit(addr_hit),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each pulse output and slave-driven SDA lows
    always @(negedge clk) begin
        if (addr_hit) n_hit++;
        if (rx_valid) begin
            n_rxv++;
            rx_log.push_back(rx_data);
        end
        if (tx_req) n_txreq++;
        if (done) n_done++;
        if (sda === 1'b0 && !m_sda_oe) n_slow++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bus primitives; every bit task starts and ends with SCL just pulled low
    task automatic bus_start();
        clks(4);
        m_sda_oe = 1'b1;
        clks(8);
        scl_r = 1'b0;
    endtask

    task automatic bus_rstart();
        clks(2);
        m_sda_oe = 1'b0;
        clks(6);
        scl_r = 1'b1;
        clks(8);
        m_sda_oe = 1'b1;
        clks(8);
        scl_r = 1'b0;
    endtask

    task automatic bus_stop();
        clks(2);
        m_sda_oe = 1'b1;
        clks(6);
        scl_r = 1'b1;
        clks(8);
        m_sda_oe = 1'b0;
        clks(10);
    endtask

    task automatic send_bit(input logic b);
        clks(2);
        m_sda_oe = ~b;
        clks(6);
        scl_r = 1'b1;
        clks(8);
        scl_r = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        clks(2);
        m_sda_oe = 1'b0;
        clks(6);
        scl_r = 1'b1;
        clks(4);
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        clks(4);
        scl_r = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] rd, input logic chg, input logic [7:0] new_tx);
        logic b;
        rd = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            rd[i] = b;
            if (i == 0 && chg) tx_data = new_tx;
        end
    endtask

    task automatic run_txn(input logic [6:0] a, input logic d, input logic [7:0] wd,
                           output logic aack, output logic dack,
                           output logic [7:0] rd, output logic bmid);
        bus_start();
        send_byte({d, a}, aack);
        bmid = busy;
        dack = 1'b1;
        rd   = '0;
        if (!aack) begin
            if (d) begin
                send_byte(wd, dack);
            end else begin
                read_byte(rd, 1'b1, ~tx_data);
                send_bit(1'b1);
            end
        end
        bus_stop();
    endtask

    typedef struct {
        logic [6:0] addr;
        logic       dir;
        logic [7:0] wdata;
        logic [7:0] tx;
        logic       exp_aack;
        logic [7:0] exp_rx;
        logic [7:0] exp_rd;
        int         exp_hit;
        int         exp_rxv;
        int         exp_txreq;
        int         exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic       aack, dack, bmid, a2;
        logic [7:0] rd, rd2;
        int h0, v0, t0, d0, s0, q0;

        n_tests = 0; n_fail = 0;
        n_hit = 0; n_rxv = 0; n_txreq = 0; n_done = 0; n_slow = 0;
        scl_r = 1'b1; m_sda_oe = 1'b0; tx_data = 8'h00;
        rst = 1'b1;

        //         addr   dir   wdata  tx     aack  exp_rx exp_rd hit rxv txr done
        vecs[0] = '{7'h48, 1'b1, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'h00, 1, 1, 0, 1};
        vecs[1] = '{7'h48, 1'b0, 8'h00, 8'h3C, 1'b0, 8'hA5, 8'h3C, 1, 0, 1, 1};
        vecs[2] = '{7'h21, 1'b1, 8'h77, 8'h00, 1'b1, 8'hA5, 8'h00, 0, 0, 0, 0};
        vecs[3] = '{7'h48, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1, 1, 0, 1};
        vecs[4] = '{7'h48, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, 8'hFF, 1, 0, 1, 1};
        vecs[5] = '{7'h49, 1'b0, 8'h00, 8'h5A, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0};
        vecs[6] = '{7'h48, 1'b1, 8'h80, 8'h00, 1'b0, 8'h80, 8'h00, 1, 1, 0, 1};
        vecs[7] = '{7'h48, 1'b0, 8'h00, 8'h01, 1'b0, 8'h80, 8'h01, 1, 0, 1, 1};

        clks(4);
        chk("reset_rx_data", {24'h0, rx_data}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_pulses", {28'h0, addr_hit, rx_valid, tx_req, done}, 32'h0);
        chk("reset_sda_released", {31'h0, sda === 1'b0}, 32'h0);
        rst = 1'b0;
        clks(10);

        // Single-byte transactions from the table
        for (int i = 0; i < 8; i++) begin
            h0 = n_hit; v0 = n_rxv; t0 = n_txreq; d0 = n_done; s0 = n_slow;
            tx_data = vecs[i].tx;
            run_txn(vecs[i].addr, vecs[i].dir, vecs[i].wdata, aack, dack, rd, bmid);
            chk($sformatf("v%0d_addr_ack", i), {31'h0, aack}, {31'h0, vecs[i].exp_aack});
            if (!vecs[i].exp_aack) begin
                chk($sformatf("v%0d_busy_mid", i), {31'h0, bmid}, 32'h1);
                if (vecs[i].dir)
                    chk($sformatf("v%0d_data_ack", i), {31'h0, dack}, 32'h0);
                else
                    chk($sformatf("v%0d_read_byte", i), {24'h0, rd}, {24'h0, vecs[i].exp_rd});
            end else begin
                chk($sformatf("v%0d_busy_mid", i), {31'h0, bmid}, 32'h0);
                chk($sformatf("v%0d_sda_quiet", i), n_slow - s0, 0);
            end
            chk($sformatf("v%0d_rx_data", i), {24'h0, rx_data}, {24'h0, vecs[i].exp_rx});
            chk($sformatf("v%0d_addr_hit", i), n_hit - h0, vecs[i].exp_hit);
            chk($sformatf("v%0d_rx_valid", i), n_rxv - v0, vecs[i].exp_rxv);
            chk($sformatf("v%0d_tx_req", i), n_txreq - t0, vecs[i].exp_txreq);
            chk($sformatf("v%0d_done", i), n_done - d0, vecs[i].exp_done);
            chk($sformatf("v%0d_busy_end", i), {31'h0, busy}, 32'h0);
        end

        // Multi-byte write
        v0 = n_rxv; d0 = n_done; q0 = rx_log.size();
        bus_start();
        send_byte({1'b1, 7'h48}, aack);
        chk("mw_addr_ack", {31'h0, aack}, 32'h0);
        send_byte(8'h11, dack);
        chk("mw_ack1", {31'h0, dack}, 32'h0);
        send_byte(8'h22, dack);
        chk("mw_ack2", {31'h0, dack}, 32'h0);
        send_byte(8'h33, dack);
        chk("mw_ack3", {31'h0, dack}, 32'h0);
        bus_stop();
        chk("mw_rx_valid", n_rxv - v0, 3);
        if (rx_log.size() >= q0 + 3) begin
            chk("mw_byte0", {24'h0, rx_log[q0]},     32'h11);
            chk("mw_byte1", {24'h0, rx_log[q0 + 1]}, 32'h22);
            chk("mw_byte2", {24'h0, rx_log[q0 + 2]}, 32'h33);
        end else begin
            chk("mw_log_size", rx_log.size() - q0, 3);
        end
        chk("mw_done", n_done - d0, 1);

        // Multi-byte read: master ACK then NACK; second byte sampled at entry
        t0 = n_txreq; d0 = n_done;
        tx_data = 8'h96;
        bus_start();
        send_byte({1'b0, 7'h48}, aack);
        chk("mr_addr_ack", {31'h0, aack}, 32'h0);
        read_byte(rd, 1'b0, 8'h00);
        chk("mr_byte1", {24'h0, rd}, 32'h96);
        tx_data = 8'h4B;
        send_bit(1'b0);
        read_byte(rd2, 1'b1, 8'hFF);
        chk("mr_byte2", {24'h0, rd2}, 32'h4B);
        send_bit(1'b1);
        bus_stop();
        chk("mr_tx_req", n_txreq - t0, 2);
        chk("mr_done", n_done - d0, 1);
        chk("mr_busy_end", {31'h0, busy}, 32'h0);

        // Repeated START: write 0x55 then read without an ACK slot
        h0 = n_hit; d0 = n_done;
        tx_data = 8'hC6;
        bus_start();
        send_byte({1'b1, 7'h48}, aack);
        send_byte(8'h55, dack);
        chk("rs_wr_ack", {30'h0, aack, dack}, 32'h0);
        bus_rstart();
        chk("rs_busy_after_rstart", {31'h0, busy}, 32'h0);
        send_byte({1'b0, 7'h48}, a2);
        chk("rs_rd_addr_ack", {31'h0, a2}, 32'h0);
        read_byte(rd, 1'b0, 8'h00);
        bus_stop();
        chk("rs_rx_data", {24'h0, rx_data}, 32'h55);
        chk("rs_read_byte", {24'h0, rd}, 32'hC6);
        chk("rs_addr_hit", n_hit - h0, 2);
        chk("rs_done", n_done - d0, 1);

        // STOP after 4 data bits: partial byte is discarded
        v0 = n_rxv; d0 = n_done;
        bus_start();
        send_byte({1'b1, 7'h48}, aack);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        chk("ab_rx_valid", n_rxv - v0, 0);
        chk("ab_rx_data", {24'h0, rx_data}, 32'h55);
        chk("ab_done", n_done - d0, 1);

        // Reset while the slave holds the address ACK low
        bus_start();
        for (int i = 0; i < 8; i++) send_bit(i == 3 || i >= 6);
        clks(2);
        m_sda_oe = 1'b0;
        clks(4);
        chk("rst_ack_driven", {31'h0, sda === 1'b0}, 32'h1);
        rst = 1'b1;
        #2;
        chk("rst_sda_released", {31'h0, sda === 1'b0}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        clks(2);
        rst = 1'b0;
        scl_r = 1'b1;
        clks(10);
        v0 = n_rxv; d0 = n_done;
        run_txn(7'h48, 1'b1, 8'h69, aack, dack, rd, bmid);
        chk("post_rst_acks", {30'h0, aack, dack}, 32'h0);
        chk("post_rst_rx_data", {24'h0, rx_data}, 32'h69);
        chk("post_rst_rx_valid", n_rxv - v0, 1);
        chk("post_rst_done", n_done - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
